// File: rtl/money_pkg.sv
// money_pkg: shared sizes, money codes, purse states and value helpers for the money ledger
package money_pkg;
    localparam int NUM_SPAWNS     = 4;
    localparam int CARRY_MAX      = 3;
    localparam int DEPOSIT_FRAMES = 30;
    localparam int SCORE_W        = 8;
    localparam int CODE_W         = 2 * NUM_SPAWNS;
    localparam int CNT_W          = $clog2(CARRY_MAX + 1);
    localparam int PTR_W          = $clog2(CARRY_MAX);
    localparam int NW             = $clog2(NUM_SPAWNS + 1);
    localparam int TMR_W          = $clog2(DEPOSIT_FRAMES);
    localparam logic [SCORE_W-1:0] VAL_SMALL = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] VAL_LARGE = SCORE_W'(3);
    typedef enum logic [1:0] {MONEY_NONE, MONEY_SMALL, MONEY_LARGE, MONEY_RSVD} money_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CARRY, ST_BANK, ST_DEAD} purse_state_t;
    function automatic logic [SCORE_W-1:0] money_value(input money_t m);
        return m == MONEY_SMALL ? VAL_SMALL : m == MONEY_LARGE ? VAL_LARGE : '0;
    endfunction
    // Reserved code 3 counts as no pickup.
    function automatic logic is_touched(input logic [1:0] c);
        return c == 2'd1 || c == 2'd2;
    endfunction
    function automatic logic [NW-1:0] count_touched(input logic [CODE_W-1:0] c);
        logic [NW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SPAWNS; i++) n = n + NW'(is_touched(c[2*i+:2]));
        return n;
    endfunction
    // Circular purse index: rd + cnt + k never exceeds 8, so 4 bits suffice.
    function automatic logic [PTR_W-1:0] wrap(input logic [3:0] x);
        return PTR_W'(x % 4'(CARRY_MAX));
    endfunction
endpackage

// File: rtl/money_ledger_if.sv
// money_ledger_if: spawner/game-side bus of the money ledger
// master: drives RoundStart, per-spawn collect codes, Dead and AtBank levels; reads acks, bags, scores, banking
// slave : the ledger, which drives the acks, bag counts, scores and banking flags
interface money_ledger_if;
    import money_pkg::*;
    logic                RoundStart;
    logic [CODE_W-1:0]   P1Collect, P2Collect;
    logic                P1Dead, P2Dead, P1AtBank, P2AtBank;
    logic                P1Collected, P2Collected;
    logic [CNT_W-1:0]    P1Bags, P2Bags;
    logic [SCORE_W-1:0]  P1Score, P2Score;
    logic                P1Banking, P2Banking;
    modport master (
        output RoundStart, P1Collect, P2Collect, P1Dead, P2Dead, P1AtBank, P2AtBank,
        input  P1Collected, P2Collected, P1Bags, P2Bags, P1Score, P2Score, P1Banking, P2Banking
    );
    modport slave (
        input  RoundStart, P1Collect, P2Collect, P1Dead, P2Dead, P1AtBank, P2AtBank,
        output P1Collected, P2Collected, P1Bags, P2Bags, P1Score, P2Score, P1Banking, P2Banking
    );
endinterface

// File: rtl/player_purse.sv
// player_purse: one player's carried-bag FIFO, carry/bank/dead FSM, deposit timer and saturating score
// clk_i, rst_n_i : frame clock, async active-low reset
// clr_i          : round start, synchronous clear with top priority
// dead_i, at_bank_i : player hit / player inside bank zone (levels)
// push_i, codes_i   : accepted pickup and the per-spawn codes to push in ascending spawn order
// bags_o, score_o, banking_o : bags carried, banked score, deposit in progress
module player_purse
    import money_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                clr_i,
    input  logic                dead_i,
    input  logic                at_bank_i,
    input  logic                push_i,
    input  logic [CODE_W-1:0]   codes_i,
    output logic [CNT_W-1:0]    bags_o,
    output logic [SCORE_W-1:0]  score_o,
    output logic                banking_o
);
    purse_state_t        state_q, state_d;
    money_t              mem_q [CARRY_MAX];
    money_t              mem_d [CARRY_MAX];
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W:0]    sum;
    logic [NW-1:0]       k;
    logic                timer_done, pop;

    assign timer_done = timer_q == TMR_W'(DEPOSIT_FRAMES - 1);
    // Leaving the bank zone, dying or a round start in the final frame all forfeit the pop.
    assign pop        = state_q == ST_BANK && at_bank_i && timer_done && !dead_i && !clr_i;
    assign sum        = {1'b0, score_q} + {1'b0, money_value(mem_q[rd_q])};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) state_d = ST_IDLE;
        else if (dead_i) state_d = ST_DEAD;
        else begin
            case (state_q)
                ST_IDLE:  state_d = push_i ? ST_CARRY : ST_IDLE;
                ST_CARRY: state_d = (at_bank_i && cnt_q != '0) ? ST_BANK : ST_CARRY;
                ST_BANK:  state_d = !at_bank_i ? ST_CARRY : (pop && cnt_q == CNT_W'(1)) ? ST_IDLE : ST_BANK;
                default:  state_d = push_i ? ST_CARRY : ST_IDLE;
            endcase
        end
    end

    always_comb begin
        banking_o = state_q == ST_BANK;
    end

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        k       = '0;
        timer_d = (clr_i || dead_i || state_q != ST_BANK || !at_bank_i || timer_done) ? '0 : timer_q + TMR_W'(1);
        score_d = clr_i ? '0 : pop ? (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]) : score_q;
        if (clr_i || dead_i) begin
            rd_d  = '0;
            cnt_d = '0;
        end else if (pop) begin
            rd_d  = wrap(4'(rd_q) + 4'd1);
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push_i) begin
            // Pop needs AtBank and an ack needs !AtBank, so push and pop never share an edge.
            for (int i = 0; i < NUM_SPAWNS; i++) begin
                if (is_touched(codes_i[2*i+:2])) begin
                    mem_d[wrap(4'(rd_q) + 4'(cnt_q) + 4'(k))] = money_t'(codes_i[2*i+:2]);
                    k = k + NW'(1);
                end
            end
            cnt_d = cnt_q + CNT_W'(k);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q   <= '{default: MONEY_NONE};
            rd_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            score_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            score_q <= score_d;
        end
    end

    assign bags_o  = cnt_q;
    assign score_o = score_q;
endmodule

// File: rtl/money_ledger.sv
// money_ledger: acks spawner pickups per player and keeps each player's purse and banked score
// FrameClk : sole clock
// Reset_n  : asynchronous active-low reset
// bus      : slave side of money_ledger_if (collect codes, Dead/AtBank levels, RoundStart in; acks, bags, scores, banking out)
module money_ledger
    import money_pkg::*;
(
    input  logic           FrameClk,
    input  logic           Reset_n,
    money_ledger_if.slave  bus
);
    logic [NW-1:0] n1, n2;

    assign n1 = count_touched(bus.P1Collect);
    assign n2 = count_touched(bus.P2Collect);
    // All-or-nothing: ack only when every touched bag fits in the purse.
    assign bus.P1Collected = n1 != '0 && !bus.P1Dead && !bus.P1AtBank && !bus.RoundStart
                             && (4'(bus.P1Bags) + 4'(n1)) <= 4'(CARRY_MAX);
    assign bus.P2Collected = n2 != '0 && !bus.P2Dead && !bus.P2AtBank && !bus.RoundStart
                             && (4'(bus.P2Bags) + 4'(n2)) <= 4'(CARRY_MAX);

    player_purse u_p1 (
        .clk_i     (FrameClk),
        .rst_n_i   (Reset_n),
        .clr_i     (bus.RoundStart),
        .dead_i    (bus.P1Dead),
        .at_bank_i (bus.P1AtBank),
        .push_i    (bus.P1Collected),
        .codes_i   (bus.P1Collect),
        .bags_o    (bus.P1Bags),
        .score_o   (bus.P1Score),
        .banking_o (bus.P1Banking)
    );

    player_purse u_p2 (
        .clk_i     (FrameClk),
        .rst_n_i   (Reset_n),
        .clr_i     (bus.RoundStart),
        .dead_i    (bus.P2Dead),
        .at_bank_i (bus.P2AtBank),
        .push_i    (bus.P2Collected),
        .codes_i   (bus.P2Collect),
        .bags_o    (bus.P2Bags),
        .score_o   (bus.P2Score),
        .banking_o (bus.P2Banking)
    );
endmodule

// File: tb/tb_money_ledger.sv
// tb_money_ledger: directed vector table plus hand-written banking/death/saturation/reset sequences
module tb_money_ledger;
    import money_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_score;

    always #5 clk = ~clk;

    money_ledger_if bus();

    money_ledger dut (
        .FrameClk (clk),
        .Reset_n  (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic       rs;
        logic [7:0] p1c, p2c;
        logic       p1d, p2d, p1b, p2b;
        logic       a1, a2;
        logic [1:0] b1, b2;
        logic       k1, k2;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.RoundStart = 1'b0;
        bus.P1Collect  = '0;
        bus.P2Collect  = '0;
        bus.P1Dead     = 1'b0;
        bus.P2Dead     = 1'b0;
        bus.P1AtBank   = 1'b0;
        bus.P2AtBank   = 1'b0;
    endtask

    task automatic clear_round();
        bus.RoundStart = 1'b1;
        step(1);
        bus.RoundStart = 1'b0;
    endtask

    // Pick up the bags in code, bank them all, leave the zone.
    task automatic trip(input logic [7:0] code, input int val);
        bus.P1Collect = code;
        step(1);
        bus.P1Collect = '0;
        bus.P1AtBank  = 1'b1;
        for (int c = 0; c < 200 && bus.P1Bags != 0; c++) step(1);
        chk("trip_emptied", int'(bus.P1Bags), 0);
        bus.P1AtBank = 1'b0;
        step(1);
        exp_score = (exp_score + val > 255) ? 255 : exp_score + val;
        chk("trip_score", int'(bus.P1Score), exp_score);
    endtask

    initial begin
        //          rs   p1c    p2c    p1d p2d p1b p2b  a1  a2  b1 b2 k1 k2
        vecs[0]  = '{0, 8'h01, 8'h00, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0};
        vecs[1]  = '{0, 8'h01, 8'h00, 0, 0, 0, 0,  1, 0, 2, 0, 0, 0};
        vecs[2]  = '{0, 8'h12, 8'h00, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0};
        vecs[3]  = '{0, 8'h00, 8'hFF, 0, 0, 0, 0,  0, 0, 2, 0, 0, 0};
        vecs[4]  = '{0, 8'h00, 8'hE4, 0, 0, 0, 0,  0, 1, 2, 2, 0, 0};
        vecs[5]  = '{0, 8'h01, 8'h00, 1, 0, 0, 0,  0, 0, 0, 2, 0, 0};
        vecs[6]  = '{0, 8'h01, 8'h00, 0, 0, 0, 0,  1, 0, 1, 2, 0, 0};
        vecs[7]  = '{0, 8'h00, 8'h01, 0, 0, 0, 1,  0, 0, 1, 2, 0, 1};
        vecs[8]  = '{0, 8'h00, 8'h40, 0, 0, 0, 0,  0, 1, 1, 3, 0, 0};
        vecs[9]  = '{0, 8'h55, 8'h00, 0, 0, 0, 0,  0, 0, 1, 3, 0, 0};
        vecs[10] = '{1, 8'h01, 8'h01, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 8'h15, 8'h00, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0};
        vecs[12] = '{0, 8'h01, 8'h2A, 0, 0, 0, 0,  0, 1, 3, 3, 0, 0};
        vecs[13] = '{0, 8'h01, 8'h00, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0};

        idle_inputs();
        #3;
        chk("rst_p1bags", int'(bus.P1Bags), 0);
        chk("rst_p2bags", int'(bus.P2Bags), 0);
        chk("rst_p1score", int'(bus.P1Score), 0);
        chk("rst_p2score", int'(bus.P2Score), 0);
        chk("rst_p1banking", int'(bus.P1Banking), 0);
        chk("rst_p1ack", int'(bus.P1Collected), 0);
        #9 rst_n = 1'b1;
        step(1);

        for (int i = 0; i < 14; i++) begin
            bus.RoundStart = vecs[i].rs;
            bus.P1Collect  = vecs[i].p1c;
            bus.P2Collect  = vecs[i].p2c;
            bus.P1Dead     = vecs[i].p1d;
            bus.P2Dead     = vecs[i].p2d;
            bus.P1AtBank   = vecs[i].p1b;
            bus.P2AtBank   = vecs[i].p2b;
            #1;
            chk($sformatf("v%0d_p1ack", i), int'(bus.P1Collected), int'(vecs[i].a1));
            chk($sformatf("v%0d_p2ack", i), int'(bus.P2Collected), int'(vecs[i].a2));
            step(1);
            chk($sformatf("v%0d_p1bags", i), int'(bus.P1Bags), int'(vecs[i].b1));
            chk($sformatf("v%0d_p2bags", i), int'(bus.P2Bags), int'(vecs[i].b2));
            chk($sformatf("v%0d_p1banking", i), int'(bus.P1Banking), int'(vecs[i].k1));
            chk($sformatf("v%0d_p2banking", i), int'(bus.P2Banking), int'(vecs[i].k2));
            chk($sformatf("v%0d_p1score", i), int'(bus.P1Score), 0);
        end
        idle_inputs();

        // small then large, banked back to back
        clear_round();
        bus.P1Collect = 8'h09;
        #1 chk("t3_ack", int'(bus.P1Collected), 1);
        step(1);
        bus.P1Collect = '0;
        chk("t3_bags", int'(bus.P1Bags), 2);
        bus.P1AtBank = 1'b1;
        step(1);
        chk("t3_banking", int'(bus.P1Banking), 1);
        step(29);
        chk("t3_score_early", int'(bus.P1Score), 0);
        step(1);
        chk("t3_score_small", int'(bus.P1Score), 1);
        chk("t3_bags_after1", int'(bus.P1Bags), 1);
        step(29);
        chk("t3_score_mid", int'(bus.P1Score), 1);
        step(1);
        chk("t3_score_large", int'(bus.P1Score), 4);
        chk("t3_bags_after2", int'(bus.P1Bags), 0);
        chk("t3_banking_end", int'(bus.P1Banking), 0);
        chk("t3_state_idle", int'(dut.u_p1.state_q), int'(ST_IDLE));
        bus.P1AtBank = 1'b0;

        // leaving the bank mid-deposit loses the partial timer
        clear_round();
        bus.P1Collect = 8'h01;
        step(1);
        bus.P1Collect = '0;
        bus.P1AtBank = 1'b1;
        step(20);
        bus.P1AtBank = 1'b0;
        step(1);
        chk("t4_score_drop", int'(bus.P1Score), 0);
        chk("t4_banking_drop", int'(bus.P1Banking), 0);
        chk("t4_bags_kept", int'(bus.P1Bags), 1);
        bus.P1AtBank = 1'b1;
        step(1);
        chk("t4_banking_again", int'(bus.P1Banking), 1);
        step(29);
        chk("t4_score_notyet", int'(bus.P1Score), 0);
        step(1);
        chk("t4_score_banked", int'(bus.P1Score), 1);
        chk("t4_bags_empty", int'(bus.P1Bags), 0);
        bus.P1AtBank = 1'b0;

        // death while banking flushes the purse
        clear_round();
        bus.P1Collect = 8'h15;
        step(1);
        bus.P1Collect = '0;
        chk("t5_bags3", int'(bus.P1Bags), 3);
        bus.P1AtBank = 1'b1;
        step(6);
        bus.P1Dead = 1'b1;
        bus.P1Collect = 8'h01;
        #1 chk("t5_dead_noack", int'(bus.P1Collected), 0);
        step(1);
        chk("t5_bags_flushed", int'(bus.P1Bags), 0);
        chk("t5_score_kept", int'(bus.P1Score), 0);
        chk("t5_banking", int'(bus.P1Banking), 0);
        chk("t5_state_dead", int'(dut.u_p1.state_q), int'(ST_DEAD));
        step(1);
        bus.P1Dead = 1'b0;
        bus.P1Collect = '0;
        step(1);
        chk("t5_state_idle", int'(dut.u_p1.state_q), int'(ST_IDLE));

        // death on the exact pop frame wins
        clear_round();
        bus.P1AtBank = 1'b0;
        bus.P1Collect = 8'h01;
        step(1);
        bus.P1Collect = '0;
        bus.P1AtBank = 1'b1;
        step(30);
        bus.P1Dead = 1'b1;
        step(1);
        chk("t5b_no_score", int'(bus.P1Score), 0);
        chk("t5b_bags", int'(bus.P1Bags), 0);
        bus.P1Dead = 1'b0;
        bus.P1AtBank = 1'b0;
        step(1);

        // P2 banks a large bag independently
        bus.P2Collect = 8'h02;
        step(1);
        bus.P2Collect = '0;
        bus.P2AtBank = 1'b1;
        step(31);
        chk("p2_score", int'(bus.P2Score), 3);
        chk("p2_p1_untouched", int'(bus.P1Score), 0);
        bus.P2AtBank = 1'b0;

        // climb to 254 then saturate
        clear_round();
        exp_score = 0;
        for (int t = 0; t < 28; t++) trip(8'h2A, 9);
        trip(8'h05, 2);
        chk("t6_at254", int'(bus.P1Score), 254);
        trip(8'h02, 3);
        chk("t6_sat255", int'(bus.P1Score), 255);
        trip(8'h02, 3);
        chk("t6_nowrap", int'(bus.P1Score), 255);

        // async reset mid-deposit
        bus.P1Collect = 8'h01;
        step(1);
        bus.P1Collect = '0;
        bus.P1AtBank = 1'b1;
        step(10);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_bags", int'(bus.P1Bags), 0);
        chk("t6b_score", int'(bus.P1Score), 0);
        chk("t6b_banking", int'(bus.P1Banking), 0);
        chk("t6b_p2score", int'(bus.P2Score), 0);
        bus.P1AtBank = 1'b0;
        #1;
        chk("t6b_ack", int'(bus.P1Collected), 0);
        #1 rst_n = 1'b1;
        step(1);

        // round start beats a pickup and clears scores
        bus.P1Collect = 8'h01;
        step(1);
        bus.RoundStart = 1'b1;
        bus.P1Collect = 8'h01;
        bus.P2Collect = 8'h01;
        #1;
        chk("t6c_p1noack", int'(bus.P1Collected), 0);
        chk("t6c_p2noack", int'(bus.P2Collected), 0);
        step(1);
        chk("t6c_p1bags", int'(bus.P1Bags), 0);
        chk("t6c_p2bags", int'(bus.P2Bags), 0);
        idle_inputs();
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
